load_store_unit: RTL and testbench
==================================

# load_store_unit

Sits between the execute stage and the word-addressed data memory (`data_mem`) of the 32-bit RISC-V core. Accepts one load or store request at a time over a valid/ready handshake. Translates the request into word-aligned `mem_read`/`mem_write` accesses, with read-modify-write for SB/SH. Returns sign- or zero-extended load data with a single-cycle response pulse.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte-address width of `req_addr` and `mem_addr`.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; a request is accepted on the edge where `req_valid && req_ready`.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3:
  - loads: LB=000, LH=001, LW=010, LBU=100, LHU=101.
  - stores: SB=000, SH=001, SW=010.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  32  store data; bytes taken from the LSBs.
- resp_valid  out  1  one-cycle completion pulse, for loads and stores.
- resp_rdata  out  32  extended load data; 0 for stores and faults; held until the next response.
- fault  out  1  valid with `resp_valid`; misaligned access or illegal funct3.
- mem_read  out  1  to `data_mem`.
- mem_write  out  1  to `data_mem`.
- mem_addr  out  ADDR_WIDTH  always `{req_addr[ADDR_WIDTH-1:2],2'b00}`, registered at accept.
- mem_wdata  out  32  full word to write.
- mem_rdata  in  32  `data_out` of `data_mem`; valid in the cycle after `mem_read` is presented.

## Operation
- FSM states: IDLE, RD, CAP, WR, DONE. Request fields are registered on accept.
- Paths from IDLE after accept:
  - load: IDLE→RD→CAP→DONE→IDLE.
  - SW: IDLE→WR→DONE→IDLE.
  - SB/SH: IDLE→RD→CAP→WR→DONE→IDLE.
  - fault: IDLE→DONE→IDLE, with no memory access.
- State actions:
  - RD: `mem_read`=1.
  - CAP: `mem_read`=1; at the exit edge, `mem_rdata` is sampled.
    - load: lane extracted and extended into `resp_rdata`.
    - SB/SH: lanes merged into the `mem_wdata` register.
  - WR: `mem_write`=1.
  - DONE: `resp_valid`=1.
- `mem_read` and `mem_write` are never high together. Both are 0 in IDLE and DONE.
- Lanes are little-endian; byte lane = `addr[1:0]`, lane 0 = bits[7:0].
  - LB/LBU select byte `addr[1:0]`.
  - LH/LHU select halfword `addr[1]`.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Merge: SB replaces byte lane `addr[1:0]` with `req_wdata[7:0]`; SH replaces halfword `addr[1]` with `req_wdata[15:0]`. Other lanes keep their memory value.
- Fault conditions (macro-dependent, see Configuration):
  - LH/LHU/SH with `addr[0]`=1.
  - LW/SW with `addr[1:0]`≠0.
  - load funct3 ∈ {011,110,111}.
  - store funct3 > 010.
- `req_valid` is ignored outside IDLE. No request queueing.

## Timing
- Reset (asynchronous, immediate) forces state IDLE, `mem_read`=0, `mem_write`=0, `resp_valid`=0, `resp_rdata`=0, `fault`=0, `mem_addr`=0, `mem_wdata`=0.
  - `req_ready`=1 once `rst` deasserts; requests are ignored while `rst` is high.
- Accept at edge E; `resp_valid` is high for exactly one cycle, starting at:
  - load: edge E+3.
  - SW: edge E+2.
  - SB/SH: edge E+4.
  - fault: edge E+1.
- `req_ready` returns to 1 at the edge ending DONE, so back-to-back requests issue every latency+1 cycles.
- Reset mid-operation abandons the access; no partial write is issued after `rst` rises. A write already committed by an earlier edge stands.
- All outputs are registered or decoded from state only. There is no combinational path from `req_*` to `mem_*`.

## Configuration
- `LSU_MISALIGN_CHECK_EN` defined: the fault conditions above are detected and faulted accesses skip memory.
- Undefined:
  - only illegal funct3 raises `fault`.
  - misaligned halfword/word accesses proceed silently: halfword lane = `addr[1]`, LW/SW ignore `addr[1:0]`.
  - `mem_addr` is still word-aligned.

## Test plan
- Reset during RD of a load: `mem_read` drops within the same cycle; state IDLE; `resp_valid` never pulses; `resp_rdata`=0.
- SW 0x8899AABB @0x4, then LW @0x4: one `mem_write` cycle, response at E+2; load `resp_rdata`=0x8899AABB, `fault`=0, response at E+3.
- With word 0x8899AABB @0x4:
  - LB @0x5 → 0xFFFFFFAA.
  - LBU @0x5 → 0x000000AA.
  - LH @0x6 → 0xFFFF8899.
  - LHU @0x6 → 0x00008899.
- SB 0x11 @0x6 on 0x8899AABB: RD, CAP, then `mem_write` with `mem_wdata`=0x8811AABB; subsequent LW @0x4 returns 0x8811AABB.
- LW @0x6 with macro: `fault`=1 and `resp_valid` at E+1, no `mem_read`/`mem_write`. Without macro: no fault, reads word @0x4.
- `req_valid` held high continuously with a new request every cycle: only one request is accepted per transaction; `req_ready`=0 from accept until after DONE.

Source files
------------

// File: rtl/load_store_unit.sv
// RV32I load/store unit over a word-addressed data_mem: lane extract/extend, SB/SH via read-modify-write; LSU_MISALIGN_CHECK_EN adds misalignment faults.
// Response pulse after accept: fault 1, SW 2, load 3, SB/SH 4 cycles; req_ready is low from accept until that pulse, req_valid ignored meanwhile.
module load_store_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  fault,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, DONE} state_t;

  typedef struct packed {
    logic        write;
    logic [2:0]  funct3;
    logic [1:0]  lane;
    logic [15:0] wdata;
    logic        fault;
  } req_t;

  state_t                r_state;
  req_t                  r_req;
  logic                  r_mem_read;
  logic                  r_mem_write;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [31:0]           r_mem_wdata;
  logic                  r_resp_valid;
  logic [31:0]           r_resp_rdata;
  logic                  r_fault;

  logic w_illegal;
  logic w_misalign;
  logic w_fault;
  logic w_accept;

  function automatic logic [31:0] f_extract(input logic [2:0] funct3, input logic [1:0] lane,
                                            input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (funct3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] f_merge(input logic [2:0] funct3, input logic [1:0] lane,
                                          input logic [31:0] word, input logic [15:0] wdata);
    logic [31:0] m;
    m = word;
    if (funct3 == 3'b000) begin
      case (lane)
        2'd0:    m[7:0]   = wdata[7:0];
        2'd1:    m[15:8]  = wdata[7:0];
        2'd2:    m[23:16] = wdata[7:0];
        default: m[31:24] = wdata[7:0];
      endcase
    end else if (lane[1]) begin
      m[31:16] = wdata;
    end else begin
      m[15:0] = wdata;
    end
    return m;
  endfunction

  always_comb begin
    w_illegal = req_write ? (req_funct3 > 3'b010)
                          : ((req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11));
`ifdef LSU_MISALIGN_CHECK_EN
    w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    w_misalign = 1'b0;
`endif
    w_fault  = w_illegal || w_misalign;
    w_accept = req_valid && (r_state == IDLE);
  end

  // Memory strobes and the response are registered alongside the state transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_req        <= '0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_fault      <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      r_fault      <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_req.write  <= req_write;
            r_req.funct3 <= req_funct3;
            r_req.lane   <= req_addr[1:0];
            r_req.wdata  <= req_wdata[15:0];
            r_req.fault  <= w_fault;
            r_mem_addr   <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
            if (req_write) r_mem_wdata <= req_wdata;
            if (w_fault) begin
              r_state <= DONE;
            end else if (req_write && (req_funct3 == 3'b010)) begin
              r_state     <= WR;
              r_mem_write <= 1'b1;
            end else begin
              r_state    <= RD;
              r_mem_read <= 1'b1;
            end
          end
        end
        RD: r_state <= CAP;
        CAP: begin
          r_mem_read <= 1'b0;
          if (r_req.write) begin
            r_mem_wdata <= f_merge(r_req.funct3, r_req.lane, mem_rdata, r_req.wdata);
            r_mem_write <= 1'b1;
            r_state     <= WR;
          end else begin
            r_resp_rdata <= f_extract(r_req.funct3, r_req.lane, mem_rdata);
            r_state      <= DONE;
          end
        end
        WR: begin
          r_mem_write <= 1'b0;
          r_state     <= DONE;
        end
        DONE: begin
          r_resp_valid <= 1'b1;
          r_fault      <= r_req.fault;
          if (r_req.write || r_req.fault) r_resp_rdata <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready  = (r_state == IDLE);
  assign mem_read   = r_mem_read;
  assign mem_write  = r_mem_write;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign fault      = r_fault;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, reset/back-to-back sequences, random traffic vs a byte-level memory model.
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        fault;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;
  int both_hi = 0;
  int busy_rdy = 0;

  logic [31:0] dmem [0:63];
  logic [7:0]  shadow [0:255];

  load_store_unit #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .fault(fault),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-addressed data_mem: synchronous write, registered read data.
  always @(posedge clk) begin
    if (mem_write) dmem[mem_addr[7:2]] <= mem_wdata;
    if (mem_read) mem_rdata <= dmem[mem_addr[7:2]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  function automatic bit model_fault(input logic w, input logic [2:0] f3, input int a);
    bit ill;
    int sz;
    ill = w ? (f3 > 3'd2) : !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    sz = 1 << f3[1:0];
`ifdef LSU_MISALIGN_CHECK_EN
    if (!ill && (a % sz) != 0) return 1'b1;
`else
    if (a < 0 || sz < 0) return 1'b1;
`endif
    return ill;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input int a);
    int sz;
    int ea;
    logic [31:0] v;
    sz = 1 << f3[1:0];
    ea = a & ~(sz - 1);
    v = '0;
    for (int i = 0; i < sz; i++) v = v | ({24'd0, shadow[ea + i]} << (8 * i));
    if (!f3[2] && sz < 4) begin
      if (v[8 * sz - 1]) v = v | (32'hFFFF_FFFF << (8 * sz));
    end
    return v;
  endfunction

  // Applies a store to the byte model; returns the full word that memory should receive.
  function automatic logic [31:0] model_store(input logic [2:0] f3, input int a, input logic [31:0] wd);
    int sz;
    int ea;
    int wa;
    sz = 1 << f3[1:0];
    ea = a & ~(sz - 1);
    wa = a & ~3;
    for (int i = 0; i < sz; i++) shadow[ea + i] = wd[8 * i +: 8];
    return {shadow[wa + 3], shadow[wa + 2], shadow[wa + 1], shadow[wa]};
  endfunction

  task automatic run_req(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic flt, output int lat, output int nrd,
                         output int nwr, output logic [31:0] wdat, output logic [31:0] maddr,
                         output logic tail);
    int g;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
    g = 0;
    while (!req_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0; nrd = 0; nwr = 0; wdat = '0; maddr = mem_addr;
    while (!resp_valid && lat < 20) begin
      if (mem_read) nrd++;
      if (mem_write) begin
        nwr++;
        wdat = mem_wdata;
      end
      if (mem_read && mem_write) both_hi++;
      if (req_ready) busy_rdy++;
      @(posedge clk); #1;
      lat++;
    end
    rd = resp_rdata;
    flt = fault;
    @(posedge clk); #1;
    tail = resp_valid;
  endtask

  typedef struct {
    logic        w;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] er;
    logic        ef;
    int          el;
    logic [31:0] ew;
  } vec_t;

  vec_t vt [0:18];

  initial begin
    logic [31:0] rd, wdat, maddr, exp_rd, exp_wd;
    logic        flt, tail, w, ef;
    logic [2:0]  f3;
    int          lat, nrd, nwr, a, el, acc, pul;
    logic [31:0] wd;

    for (int i = 0; i < 64; i++) dmem[i] = '0;
    for (int i = 0; i < 256; i++) shadow[i] = '0;
    req_valid = 1'b0; req_write = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    mem_rdata = '0;

    vt[0]  = '{1'b1, 3'b010, 32'h4, 32'h8899AABB, 32'h0, 1'b0, 2, 32'h8899AABB};
    vt[1]  = '{1'b0, 3'b010, 32'h4, 32'h0, 32'h8899AABB, 1'b0, 3, 32'h0};
    vt[2]  = '{1'b0, 3'b000, 32'h5, 32'h0, 32'hFFFFFFAA, 1'b0, 3, 32'h0};
    vt[3]  = '{1'b0, 3'b100, 32'h5, 32'h0, 32'h000000AA, 1'b0, 3, 32'h0};
    vt[4]  = '{1'b0, 3'b001, 32'h6, 32'h0, 32'hFFFF8899, 1'b0, 3, 32'h0};
    vt[5]  = '{1'b0, 3'b101, 32'h6, 32'h0, 32'h00008899, 1'b0, 3, 32'h0};
    vt[6]  = '{1'b1, 3'b000, 32'h6, 32'hFFFFFF11, 32'h0, 1'b0, 4, 32'h8811AABB};
    vt[7]  = '{1'b0, 3'b010, 32'h4, 32'h0, 32'h8811AABB, 1'b0, 3, 32'h0};
`ifdef LSU_MISALIGN_CHECK_EN
    vt[8]  = '{1'b0, 3'b010, 32'h6, 32'h0, 32'h0, 1'b1, 1, 32'h0};
    vt[9]  = '{1'b0, 3'b001, 32'h5, 32'h0, 32'h0, 1'b1, 1, 32'h0};
    vt[17] = '{1'b1, 3'b010, 32'h9, 32'h01020304, 32'h0, 1'b1, 1, 32'h0};
    vt[18] = '{1'b0, 3'b010, 32'h8, 32'h0, 32'h0, 1'b0, 3, 32'h0};
`else
    vt[8]  = '{1'b0, 3'b010, 32'h6, 32'h0, 32'h8811AABB, 1'b0, 3, 32'h0};
    vt[9]  = '{1'b0, 3'b001, 32'h5, 32'h0, 32'hFFFFAABB, 1'b0, 3, 32'h0};
    vt[17] = '{1'b1, 3'b010, 32'h9, 32'h01020304, 32'h0, 1'b0, 2, 32'h01020304};
    vt[18] = '{1'b0, 3'b010, 32'h8, 32'h0, 32'h01020304, 1'b0, 3, 32'h0};
`endif
    vt[10] = '{1'b0, 3'b011, 32'h8, 32'h0, 32'h0, 1'b1, 1, 32'h0};
    vt[11] = '{1'b1, 3'b100, 32'h8, 32'h5A5A5A5A, 32'h0, 1'b1, 1, 32'h0};
    vt[12] = '{1'b1, 3'b001, 32'h2, 32'h1234CAFE, 32'h0, 1'b0, 4, 32'hCAFE0000};
    vt[13] = '{1'b0, 3'b101, 32'h2, 32'h0, 32'h0000CAFE, 1'b0, 3, 32'h0};
    vt[14] = '{1'b0, 3'b001, 32'h2, 32'h0, 32'hFFFFCAFE, 1'b0, 3, 32'h0};
    vt[15] = '{1'b0, 3'b100, 32'h3, 32'h0, 32'h000000CA, 1'b0, 3, 32'h0};
    vt[16] = '{1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 3, 32'h0};

    // Reset state
    rst = 1'b1;
    #3;
    chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
    chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);

    // Directed vector table
    for (int i = 0; i < 19; i++) begin
      run_req(vt[i].w, vt[i].f3, vt[i].a, vt[i].wd, rd, flt, lat, nrd, nwr, wdat, maddr, tail);
      chk($sformatf("vec%0d_rdata", i), rd, vt[i].er);
      chk($sformatf("vec%0d_fault", i), {31'd0, flt}, {31'd0, vt[i].ef});
      chk($sformatf("vec%0d_latency", i), lat, vt[i].el);
      chk($sformatf("vec%0d_pulse", i), {31'd0, tail}, 32'd0);
      chk($sformatf("vec%0d_nread", i), nrd, (vt[i].ef || (vt[i].w && vt[i].f3 == 3'b010)) ? 0 : 2);
      chk($sformatf("vec%0d_nwrite", i), nwr, (vt[i].w && !vt[i].ef) ? 1 : 0);
      if (vt[i].w && !vt[i].ef) begin
        chk($sformatf("vec%0d_wdata", i), wdat, vt[i].ew);
        void'(model_store(vt[i].f3, int'(vt[i].a), vt[i].wd));
      end
    end

    // Reset during RD of a load
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h4;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rd_mem_read_before_rst", {31'd0, mem_read}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rd_rst_mem_read", {31'd0, mem_read}, 32'd0);
    chk("rd_rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rd_rst_rdata", resp_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pul = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (resp_valid) pul++;
    end
    chk("rd_rst_no_resp", pul, 0);

    // Reset during WR of an SB: the write must not land
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b000; req_addr = 32'h21; req_wdata = 32'h77;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("wr_mem_write_before_rst", {31'd0, mem_write}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("wr_rst_mem_write", {31'd0, mem_write}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_req(1'b0, 3'b010, 32'h20, 32'h0, rd, flt, lat, nrd, nwr, wdat, maddr, tail);
    chk("wr_rst_word_intact", rd, model_load(3'b010, 32'h20));

    // req_valid held high: one accept per transaction
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h4;
    acc = 0; pul = 0;
    for (int c = 0; c < 16; c++) begin
      if (req_ready) acc++;
      @(posedge clk); #1;
      if (resp_valid) pul++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("b2b_accepts", acc, 4);
    chk("b2b_responses", pul, 4);
    repeat (4) @(negedge clk);

    // Random traffic against the byte model
    for (int n = 0; n < 150; n++) begin
      w  = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = int'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) a = a & ~((1 << f3[1:0]) - 1);
      wd = $urandom;
      ef = model_fault(w, f3, a);
      el = ef ? 1 : (!w ? 3 : (f3 == 3'b010 ? 2 : 4));
      exp_rd = (ef || w) ? 32'h0 : model_load(f3, a);
      run_req(w, f3, a, wd, rd, flt, lat, nrd, nwr, wdat, maddr, tail);
      chk($sformatf("rnd%0d_rdata", n), rd, exp_rd);
      chk($sformatf("rnd%0d_fault", n), {31'd0, flt}, {31'd0, ef});
      chk($sformatf("rnd%0d_latency", n), lat, el);
      chk($sformatf("rnd%0d_nwrite", n), nwr, (w && !ef) ? 1 : 0);
      if (!ef) chk($sformatf("rnd%0d_addr", n), maddr, a & ~3);
      if (w && !ef) begin
        exp_wd = model_store(f3, a, wd);
        chk($sformatf("rnd%0d_wdata", n), wdat, exp_wd);
      end
    end

    chk("never_read_and_write", both_hi, 0);
    chk("ready_low_while_busy", busy_rdy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1);
  end

endmodule
